// File: rtl/tank_actuator_ctrl.sv
// Tank actuator controller: debounced level probes and a one-hot Moore FSM driving valve, mixer and drain.
// Optional fill watchdog is built only when TANK_FILL_TIMEOUT_EN is defined.
module tank_actuator_ctrl #(
  parameter int unsigned DEB_CYC  = 4,
  parameter int unsigned FILL_TMO = 1000,
  parameter int unsigned MIX_CYC  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic Ve,
  input  logic Mist,
  input  logic Limp,
  input  logic nv1_raw,
  input  logic nv0_raw,
  input  logic fault_clr,
  output logic Nv1,
  output logic Nv0,
  output logic valve_drv,
  output logic mixer_drv,
  output logic drain_drv,
  output logic fault
);

  localparam int unsigned DEB_W = 8;
  localparam int unsigned MIX_W = 8;

  // Parameter range guard, evaluated at elaboration.
  if (DEB_CYC < 1 || DEB_CYC > 255 || MIX_CYC < 1 || MIX_CYC > 255 ||
      FILL_TMO < 1 || FILL_TMO > 65535) begin : g_bad_param
    $error("tank_actuator_ctrl: parameter out of range");
  end

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    FILL  = 5'b00010,
    MIX   = 5'b00100,
    CLEAN = 5'b01000,
    FAULT = 5'b10000
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       lvl;
  logic [DEB_W-1:0] deb_cnt [2];
  logic [MIX_W-1:0] mix_cnt;
  logic             mix_done;
  logic             fill_tmo;
  logic             full;
  logic             empty;
  logic             incons;

  // Probe synchronizers and per-probe stability counters; index 1 = high probe, 0 = low probe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      lvl        <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= {nv1_raw, nv0_raw};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
          lvl[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign Nv1    = lvl[1];
  assign Nv0    = lvl[0];
  assign full   = lvl[1] & lvl[0];
  assign empty  = ~lvl[1] & ~lvl[0];
  assign incons = lvl[1] & ~lvl[0];

  // Mixer dwell counter; zero everywhere outside MIX so it restarts on each entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mix_cnt <= '0;
    end else if (state != MIX) begin
      mix_cnt <= '0;
    end else if (!mix_done) begin
      mix_cnt <= mix_cnt + MIX_W'(1);
    end
  end

  assign mix_done = (mix_cnt == MIX_W'(MIX_CYC - 1));

`ifdef TANK_FILL_TIMEOUT_EN
  localparam int unsigned TMO_W = 16;

  logic [TMO_W-1:0] fill_cnt;

  // Fill watchdog: fires on the FILL_TMO-th consecutive FILL cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt <= '0;
    end else if (state != FILL) begin
      fill_cnt <= '0;
    end else if (!fill_tmo) begin
      fill_cnt <= fill_cnt + TMO_W'(1);
    end
  end

  assign fill_tmo = (fill_cnt == TMO_W'(FILL_TMO - 1));
`else
  assign fill_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; an inconsistent level overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Ve && !full) begin
          state_nxt = FILL;
        end else if (Mist) begin
          state_nxt = MIX;
        end else if (Limp && !empty) begin
          state_nxt = CLEAN;
        end
      end
      FILL: begin
        if (full || !Ve) begin
          state_nxt = IDLE;
        end else if (fill_tmo) begin
          state_nxt = FAULT;
        end
      end
      MIX: begin
        if (mix_done && !Mist) begin
          state_nxt = IDLE;
        end
      end
      CLEAN: begin
        if (empty || !Limp) begin
          state_nxt = IDLE;
        end
      end
      FAULT: begin
        if (fault_clr && !incons) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (incons) begin
      state_nxt = FAULT;
    end
  end

  // Moore decode; one-hot encoding makes each drive a single state flop.
  always_comb begin
    valve_drv = 1'b0;
    mixer_drv = 1'b0;
    drain_drv = 1'b0;
    fault     = 1'b0;
    case (state)
      FILL:    valve_drv = 1'b1;
      MIX:     mixer_drv = 1'b1;
      CLEAN:   drain_drv = 1'b1;
      FAULT:   fault     = 1'b1;
      default: ;
    endcase
  end

endmodule
